// File: rtl/mem_pkg.sv
// Shared memory-subsystem widths plus the arbiter state encoding.
// Imported by rr_burst_arbiter and its helpers.
package mem_pkg;

    localparam int ADDR_W     = 16;
    localparam int BLOCK_BITS = 32;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit scanning from ptr
// upward with wrap. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!hit && req[j]) begin
                hit = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Work-conserving round-robin burst arbiter with beat cap.
// Optional per-port beat counters: define ARB_STATS_EN.
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int DATA_W    = mem_pkg::BLOCK_BITS,
    parameter int MAX_BEATS = 8
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         last_i,
    input  logic [N*ADDR_W-1:0]  addr_i,
    input  logic [N*DATA_W-1:0]  data_i,
    output logic [N-1:0]         gnt_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [DATA_W-1:0]    data_o,
    output logic                 last_o,
    output logic [$clog2(N)-1:0] port_o,
`ifdef ARB_STATS_EN
    input  logic                 clr_stats_i,
    output logic [N*CNT_W-1:0]   stats_o,
`endif
    output logic                 busy_o
);

    import mem_pkg::*;

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_e    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    logic [CW-1:0] beat_cnt;

    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_hit;
    logic          acc;
    logic          cap;
    logic          rel;

    assign busy_o  = (state == BURST);
    assign port_o  = owner;
    assign valid_o = busy_o & req_i[owner];
    assign acc     = valid_o & ready_i;
    assign last_o  = busy_o & last_i[owner];
    assign gnt_o   = acc ? (N'(1) << owner) : '0;

    assign addr_o = addr_i[owner*ADDR_W +: ADDR_W];
    assign data_o = data_i[owner*DATA_W +: DATA_W];

    assign cap = acc && (beat_cnt == CW'(MAX_BEATS - 1));
    assign rel = busy_o
               && (!req_i[owner]
                   || (acc && last_i[owner])
                   || cap);

    assign nxt_ptr = (owner == IW'(N - 1)) ? '0
                                           : owner + 1'b1;

    // On release the scan already starts past the old owner.
    assign pick_ptr = busy_o ? nxt_ptr : ptr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req_i),
        .ptr (pick_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (rel) begin
                        ptr      <= nxt_ptr;
                        beat_cnt <= '0;
                        if (pick_hit) begin
                            owner <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clr_stats_i) begin
                    cnt[i] <= '0;
                end else if (gnt_o[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stats_o = '0;
        for (int i = 0; i < N; i++) begin
            stats_o[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter, N=4, MAX_BEATS=8.
// Define ARB_STATS_EN to also exercise the counters (CNT_W=4).
module tb_rr_burst_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   last;
    logic [63:0]  addr_in;
    logic [127:0] data_in;
    logic [3:0]   gnt;
    logic         valid;
    logic         ready;
    logic [15:0]  addr_out;
    logic [31:0]  data_out;
    logic         last_out;
    logic [1:0]   port;
    logic         busy;
`ifdef ARB_STATS_EN
    logic         clr;
    logic [15:0]  stats;
`endif

    int vectors;
    int miscompares;

    rr_burst_arbiter #(
        .N         (4),
        .ADDR_W    (16),
        .DATA_W    (32),
        .MAX_BEATS (8)
`ifdef ARB_STATS_EN
        ,
        .CNT_W     (4)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .last_i      (last),
        .addr_i      (addr_in),
        .data_i      (data_in),
        .gnt_o       (gnt),
        .valid_o     (valid),
        .ready_i     (ready),
        .addr_o      (addr_out),
        .data_o      (data_out),
        .last_o      (last_out),
        .port_o      (port),
`ifdef ARB_STATS_EN
        .clr_stats_i (clr),
        .stats_o     (stats),
`endif
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        ready = 1'b1;
`ifdef ARB_STATS_EN
        clr   = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        last  = 4'b1111;
        ready = 1'b1;
        #1;
        vectors++;
        if ({gnt, valid, last_out, port, busy} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outs got %b want 0",
                     {gnt, valid, last_out, port, busy});
        end
        vectors++;
        if (addr_out !== 16'h1000 || data_out !== 32'hD000_0000) begin
            miscompares++;
            $display("FAIL reset_mux got %h/%h want 1000/d0000000",
                     addr_out, data_out);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold gnt %b busy %b want 0/0",
                     gnt, busy);
        end
        req  = '0;
        last = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] t_req  [9] = '{4'b0110, 4'b0110, 4'b0110,
                                   4'b0110, 4'b0100, 4'b0100,
                                   4'b0100, 4'b0000, 4'b0000};
        logic [3:0] t_last [9] = '{4'b0000, 4'b0000, 4'b0000,
                                   4'b0010, 4'b0000, 4'b0000,
                                   4'b0100, 4'b0000, 4'b0000};
        logic [3:0] t_gnt  [9] = '{4'b0000, 4'b0010, 4'b0010,
                                   4'b0010, 4'b0100, 4'b0100,
                                   4'b0100, 4'b0000, 4'b0000};
        logic [1:0] t_port [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                   2'd2, 2'd2, 2'd2, 2'd2};
        logic       t_busy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b0};
        logic       t_vld  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req  = t_req[c];
            last = t_last[c];
            #1;
            vectors++;
            if (gnt !== t_gnt[c] || port !== t_port[c]
                || busy !== t_busy[c] || valid !== t_vld[c]) begin
                miscompares++;
                $display("FAIL b2b c%0d got g%b p%0d b%b v%b want g%b p%0d b%b v%b",
                         c, gnt, port, busy, valid,
                         t_gnt[c], t_port[c], t_busy[c], t_vld[c]);
            end
            if (c == 1) begin
                vectors++;
                if (data_out !== 32'hD000_0001
                    || addr_out !== 16'h1001) begin
                    miscompares++;
                    $display("FAIL b2b_mux got %h/%h want 1001/d0000001",
                             addr_out, data_out);
                end
            end
            if (c == 3 || c == 6) begin
                vectors++;
                if (last_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_last c%0d got %b want 1",
                             c, last_out);
                end
            end
        end
    endtask

    task automatic test_beat_cap();
        // seg: count, req, last on final beat, gnt, owner
        int         s_n    [4] = '{8, 2, 8, 4};
        logic [3:0] s_req  [4] = '{4'b1001, 4'b1001,
                                   4'b0001, 4'b0001};
        logic [3:0] s_last [4] = '{4'b0000, 4'b1000,
                                   4'b0000, 4'b0001};
        logic [3:0] s_gnt  [4] = '{4'b0001, 4'b1000,
                                   4'b0001, 4'b0001};
        logic [1:0] s_port [4] = '{2'd0, 2'd3, 2'd0, 2'd0};
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        #1;
        vectors++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL cap_idle got b%b g%b want 0/0000",
                     busy, gnt);
        end
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < s_n[s]; b++) begin
                @(negedge clk);
                req  = s_req[s];
                last = (b == s_n[s] - 1) ? s_last[s] : 4'b0000;
                #1;
                vectors++;
                if (gnt !== s_gnt[s] || port !== s_port[s]
                    || valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cap s%0d b%0d got g%b p%0d v%b want g%b p%0d v1",
                             s, b, gnt, port, valid,
                             s_gnt[s], s_port[s]);
                end
            end
        end
        @(negedge clk);
        req  = 4'b0000;
        last = 4'b0000;
        #1;
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0 || gnt !== 4'b0000
            || port !== 2'd0) begin
            miscompares++;
            $display("FAIL cap_drop got b%b v%b g%b p%0d want 1/0/0000/0",
                     busy, valid, gnt, port);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cap_idle_end got %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        req = 4'b1100;
        @(negedge clk);
        #1;
        vectors++;
        if (gnt !== 4'b0100 || port !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_first got g%b p%0d want 0100/2",
                     gnt, port);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ready = 1'b0;
            #1;
            vectors++;
            if (valid !== 1'b1 || gnt !== 4'b0000
                || port !== 2'd2 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall c%0d got v%b g%b p%0d b%b want 1/0000/2/1",
                         c, valid, gnt, port, busy);
            end
        end
        // seven more beats reach the cap only if stalls were not counted
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ready = 1'b1;
            #1;
            vectors++;
            if (gnt !== 4'b0100 || port !== 2'd2) begin
                miscompares++;
                $display("FAIL stall_resume c%0d got g%b p%0d want 0100/2",
                         c, gnt, port);
            end
        end
        @(negedge clk);
        last = 4'b1000;
        #1;
        vectors++;
        if (gnt !== 4'b1000 || port !== 2'd3) begin
            miscompares++;
            $display("FAIL stall_handover got g%b p%0d want 1000/3",
                     gnt, port);
        end
        @(negedge clk);
        req  = 4'b0000;
        last = 4'b0000;
        #1;
        vectors++;
        if (port !== 2'd2 || busy !== 1'b1 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_repick got p%0d b%b v%b want 2/1/0",
                     port, busy, valid);
        end
    endtask

    task automatic test_abandon();
        logic [3:0] others [3] = '{4'b1010, 4'b0011, 4'b0010};
        logic [1:0] nxt    [3] = '{2'd3, 2'd0, 2'd1};
        logic [3:0] eg;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            @(negedge clk);
            req = 4'b0100;
            @(negedge clk);
            req = 4'b0100 | others[s];
            #1;
            vectors++;
            if (gnt !== 4'b0100) begin
                miscompares++;
                $display("FAIL abandon_beat s%0d got %b want 0100",
                         s, gnt);
            end
            @(negedge clk);
            req = others[s];
            #1;
            vectors++;
            if (valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL abandon_drop s%0d got v%b g%b b%b want 0/0000/1",
                         s, valid, gnt, busy);
            end
            @(negedge clk);
            #1;
            eg = 4'b0001 << nxt[s];
            vectors++;
            if (port !== nxt[s] || gnt !== eg) begin
                miscompares++;
                $display("FAIL abandon_next s%0d got p%0d g%b want p%0d g%b",
                         s, port, gnt, nxt[s], eg);
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        #1;
        vectors++;
        if (port !== 2'd2 || gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL rstmid_pre got p%0d g%b want 2/0100",
                     port, gnt);
        end
        @(negedge clk);
        req   = 4'b1101;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, valid, last_out, port, busy} !== 9'd0
            || addr_out !== 16'h1000) begin
            miscompares++;
            $display("FAIL rstmid_abort got %b addr %h want 0/1000",
                     {gnt, valid, last_out, port, busy}, addr_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (port !== 2'd0 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_restart got p%0d g%b want 0/0001",
                     port, gnt);
        end
        req = 4'b0000;
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (stats !== 16'h0000) begin
            miscompares++;
            $display("FAIL stats_reset got %h want 0000", stats);
        end
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (k == 3) begin
                vectors++;
                if (stats !== 16'h0030) begin
                    miscompares++;
                    $display("FAIL stats_three got %h want 0030", stats);
                end
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (stats !== 16'h00F0) begin
            miscompares++;
            $display("FAIL stats_sat got %h want 00f0", stats);
        end
        clr = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL stats_clr_beat got %b want 0010", gnt);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        vectors++;
        if (stats !== 16'h0000) begin
            miscompares++;
            $display("FAIL stats_clr got %h want 0000", stats);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (stats !== 16'h0010) begin
            miscompares++;
            $display("FAIL stats_after_clr got %h want 0010", stats);
        end
        req = 4'b0000;
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        req         = '0;
        last        = '0;
        ready       = 1'b1;
`ifdef ARB_STATS_EN
        clr         = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            addr_in[i*16 +: 16]  = 16'h1000 + 16'(i);
            data_in[i*32 +: 32]  = 32'hD000_0000 + 32'(i);
        end
        test_reset();
        test_back_to_back();
        test_beat_cap();
        test_stall();
        test_abandon();
        test_reset_midburst();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Work-conserving, request-driven round-robin arbiter that replaces fixed time-slot rotation for shared switch resources: packet-buffer write port, free-list allocator, address-learn lookup. N requesters (RX write controllers) present burst traffic. One owner is granted at a time and holds the grant until its burst ends, abandons, or hits a beat cap. Sits between the per-port memory write controllers and the single shared downstream consumer.

## Interface
- N, 4, requester count (≥2, any integer)
- ADDR_W, mem_pkg::ADDR_W, address width
- DATA_W, mem_pkg::BLOCK_BITS, payload width
- MAX_BEATS, 8, beats before forced release (≥1)
- CNT_W, 16, per-port statistics counter width (ARB_STATS_EN only)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  N  requester i has a valid beat
- last_i  in  N  beat from i is end of burst
- addr_i  in  N×ADDR_W  per-requester address
- data_i  in  N×DATA_W  per-requester payload
- gnt_o  out  N  one-hot; beat from i accepted this cycle
- valid_o  out  1  owner beat valid to consumer
- ready_i  in  1  consumer accepts beat
- addr_o / data_o  out  ADDR_W / DATA_W  owner's address/payload
- last_o  out  1  owner's last_i
- port_o  out  $clog2(N)  current owner index
- busy_o  out  1  state is BURST
- clr_stats_i  in  1  synchronous clear of counters (ARB_STATS_EN only)
- stats_o  out  N×CNT_W  accepted-beat count per port (ARB_STATS_EN only)

## Operation
- State machine: IDLE, BURST. Registers: owner, ptr (priority start), beat_cnt ($clog2(MAX_BEATS+1) bits).
- Pick: first i with req_i[i]=1 scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- IDLE: any req_i → owner ← pick, beat_cnt ← 0, go BURST. No req → stay.
- BURST: valid_o = req_i[owner]; addr_o/data_o/last_o muxed from owner; gnt_o[owner] = valid_o & ready_i; beat_cnt increments on each accepted beat.
- Release fires on any of:
  - accepted beat with last_i[owner]=1
  - accepted beat bringing beat_cnt to MAX_BEATS (forced release; requester keeps req_i and continues later)
  - req_i[owner]=0 (abandon)
- On release: ptr ← (owner+1) mod N, with wrap N-1→0. Re-pick from ptr (new value) in the same cycle. A hit loads new owner, beat_cnt ← 0, stays BURST. No hit → IDLE. Old owner therefore has lowest priority for the next grant.
- Simultaneous last_i and MAX_BEATS: a single release.
- ready_i=0: beat stalls and owner is held; no timeout.
- gnt_o is never high for a non-owner. gnt_o is never high in IDLE.
- Reset mid-burst: immediate abort. State IDLE, owner=0, ptr=0, beat_cnt=0, counters 0.
- Reset values of outputs: gnt_o=0, valid_o=0, last_o=0, port_o=0, busy_o=0, stats_o=0. addr_o/data_o reflect requester 0's inputs.

## Timing
- req_i rise in IDLE → valid_o one cycle later.
- Handover between back-to-back bursts: zero bubble cycles.
- ready_i → gnt_o is combinational. Datapath valid/addr/data/last are combinational from the registered owner.
- Throughput is one beat/cycle while ready_i=1.

## Configuration
- ARB_STATS_EN defined:
  - Per-port saturating CNT_W counters increment on gnt_o[i] and stick at 2^CNT_W-1.
  - clr_stats_i zeroes all counters next cycle; clear wins over a simultaneous increment.
- ARB_STATS_EN undefined: clr_stats_i and stats_o ports and their logic are absent.

## Structure
- mem_pkg: ADDR_W, BLOCK_BITS (existing). Add arb_state_e (IDLE, BURST).
- Sub-module rr_pick #(N): combinational rotating-priority encoder, inputs req, ptr; outputs hit, idx.

## Test plan
- N=4, req_i=0b0110 from reset, ready_i=1, 3-beat bursts → port 1 gets 3 beats, then port 2 with no bubble; gnt_o=0b0010×3 then 0b0100×3.
- Port 0 holds req 20 beats, no last_i, MAX_BEATS=8; port 3 requests → 0:8 beats, 3:burst, 0:8 beats, 0:4 beats; port_o switches at each cap.
- ready_i low 5 cycles mid-burst → valid_o stays 1, gnt_o=0, beat_cnt and owner unchanged.
- Owner 2 drops req_i after 1 beat, port 1 requesting → release; next owner 3 if requesting, else 0, else 1 (ptr=3 wrap).
- rst_n asserted mid-burst → all outputs 0 immediately; after release, arbitration restarts from port 0.
- ARB_STATS_EN, CNT_W=4: 20 beats from port 1 → stats_o[1]=15. clr_stats_i with a concurrent beat → 0.
